// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the two-requester memory arbiter.
package mem_arb_pkg;

  localparam int DEF_ADDR_W = 8;
  localparam int DEF_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SERVE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way round-robin winner select: a sole requester wins; on a tie the
// requester that was not granted last time wins.
module mem_arb_rr (
  input  logic [1:0] req,
  input  logic       last_grant,
  output logic       valid,
  output logic       winner
);

  assign valid  = |req;
  assign winner = (&req) ? ~last_grant : req[1];

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter: IDLE -> SERVE -> DONE -> IDLE.
// Optional macro MEM_ARB_LOCK_EN adds a lock input for back-to-back owner accesses.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
`ifdef MEM_ARB_LOCK_EN
  input  logic [1:0]        lock,
`endif
  output logic [1:0]        ack,
  output logic [DATA_W-1:0] rdata,
  output logic              busy,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  state_t state;
  logic   owner;
  logic   last_grant;
  logic   rr_valid;
  logic   rr_winner;

  // The requester whose inputs load the memory port on entry to SERVE.
  logic              sel;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  mem_arb_rr u_rr (
    .req        (req),
    .last_grant (last_grant),
    .valid      (rr_valid),
    .winner     (rr_winner)
  );

  assign sel       = (state == IDLE) ? rr_winner : owner;
  assign sel_we    = we[sel];
  assign sel_addr  = sel ? addr1 : addr0;
  assign sel_wdata = sel ? wdata1 : wdata0;

  // NOTE: the memory port is registered and cleared by the asynchronous
  // reset, so a reset during SERVE drops mem_we before the commit edge.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      owner      <= 1'b0;
      last_grant <= 1'b1;
      rdata      <= '0;
      ack        <= '0;
      busy       <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      // NOTE: every state register uses non-blocking assignment so all
      // reads in this block see the pre-edge values.
      ack       <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      unique case (state)
        IDLE: begin
          if (rr_valid) begin
            state     <= SERVE;
            owner     <= rr_winner;
            busy      <= 1'b1;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end
        end
        SERVE: begin
          state      <= DONE;
          rdata      <= mem_rdata;
          last_grant <= owner;
          ack        <= owner ? 2'b10 : 2'b01;
        end
        DONE: begin
`ifdef MEM_ARB_LOCK_EN
          if (lock[owner] && req[owner]) begin
            state     <= SERVE;
            mem_we    <= sel_we;
            mem_addr  <= sel_addr;
            mem_wdata <= sel_wdata;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
`else
          state <= IDLE;
          busy  <= 1'b0;
`endif
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural memory; covers the lock
// path as well when MEM_ARB_LOCK_EN is defined.
module tb_mem_arbiter;

  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk;
  logic          reset;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic [1:0]    lock;
  logic [1:0]    ack;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;

  int vectors = 0;
  int errors  = 0;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .we        (we),
    .addr0     (addr0),
    .addr1     (addr1),
    .wdata0    (wdata0),
    .wdata1    (wdata1),
`ifdef MEM_ARB_LOCK_EN
    .lock      (lock),
`endif
    .ack       (ack),
    .rdata     (rdata),
    .busy      (busy),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory preloaded with addr ^ 0x5A on the first edge (reset is low then).
  logic [DW-1:0] mem [256];
  logic          mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= DW'(i) ^ 8'h5A;
      mem_ready <= 1'b1;
    end else if (mem_we) begin
      mem[mem_addr] <= mem_wdata;
    end
  end
  assign mem_rdata = mem[mem_addr];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Invariants: ack one-hot or idle; mem_we only in SERVE (busy, no ack).
  always @(negedge clk) begin
    check("ack_excl", {31'd0, ack == 2'b11}, 32'd0);
    check("we_in_serve", {31'd0, mem_we & ~(busy & ~|ack)}, 32'd0);
  end

  initial begin
    reset = 1'b0; req = '0; we = '0; lock = '0;
    addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ack",   ack,    0);
    check("rst_busy",  busy,   0);
    check("rst_rdata", rdata,  0);
    check("rst_memwe", mem_we, 0);
    reset = 1'b1;
    tick();

    // Requester 0 writes 0xA5 to 0x10.
    req = 2'b01; we = 2'b01; addr0 = 8'h10; wdata0 = 8'hA5;
    tick();
    check("w_serve_we",   mem_we,    1);
    check("w_serve_addr", mem_addr,  8'h10);
    check("w_serve_data", mem_wdata, 8'hA5);
    check("w_serve_ack",  ack,       0);
    check("w_serve_busy", busy,      1);
    tick();
    check("w_done_ack",   ack,       2'b01);
    check("w_done_we",    mem_we,    0);
    check("w_done_rdata", rdata,     8'h4A);
    check("w_mem",        mem[8'h10], 8'hA5);
    req = 2'b00; we = 2'b00;
    tick();
    check("w_idle_ack",  ack,  0);
    check("w_idle_busy", busy, 0);

    // Requester 1 reads back 0x10.
    req = 2'b10; addr1 = 8'h10;
    tick();
    check("r_serve_we",   mem_we,   0);
    check("r_serve_addr", mem_addr, 8'h10);
    tick();
    check("r_done_ack",   ack,   2'b10);
    check("r_done_rdata", rdata, 8'hA5);
    req = 2'b00;
    tick();

    // Both held: last grant was 1, so 0 first, alternating every 3 cycles.
    req = 2'b11; addr0 = 8'h01; addr1 = 8'h02;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("rr_serve_ack", ack, 0);
      tick();
      check("rr_ack",   ack,   (k % 2 == 0) ? 2'b01 : 2'b10);
      check("rr_rdata", rdata, (k % 2 == 0) ? 8'h5B : 8'h58);
      if (k == 3) req = 2'b00;
      tick();
      check("rr_idle_ack", ack, 0);
    end

    // Reset during SERVE of a write must abort it.
    req = 2'b01; we = 2'b01; addr0 = 8'h20; wdata0 = 8'h3C;
    tick();
    check("ab_serve_we", mem_we, 1);
    #2 reset = 1'b0;
    #1;
    check("ab_busy",  busy,   0);
    check("ab_memwe", mem_we, 0);
    check("ab_ack",   ack,    0);
    req = 2'b00; we = 2'b00;
    tick();
    check("ab_mem",      mem[8'h20], 8'h7A);
    check("ab_ack_edge", ack,        0);
    reset = 1'b1;
    tick();
    check("ab_idle", busy, 0);

    // First tie after reset goes to requester 0.
    req = 2'b11; addr0 = 8'h01; addr1 = 8'h02;
    tick();
    tick();
    check("post_rst_ack", ack, 2'b01);
    req = 2'b00;
    tick();

`ifdef MEM_ARB_LOCK_EN
    reset = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    lock = 2'b01; req = 2'b11;
    tick();
    for (int k = 0; k < 3; k++) begin
      check("lk_serve_ack", ack, 0);
      tick();
      check("lk_ack", ack, 2'b01);
      if (k == 2) lock = 2'b00;
      tick();
    end
    check("lk_release_busy", busy, 0);
    tick();
    tick();
    check("lk_then_1", ack, 2'b10);
    req = 2'b00;
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
